// File: rtl/carry_chain_seq_adder.sv
// Multi-cycle wide adder: one SLICE-bit ripple slice per clock, LSB slice first,
// with the inter-slice carry held in a register. Operands and result use valid/ready.
module carry_chain_seq_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_params
    $error("carry_chain_seq_adder: WIDTH must be a nonzero multiple of SLICE");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic [SLICE:0]   chain;

  assign slice_a = a_q[idx_q*SLICE +: SLICE];
  assign slice_b = b_q[idx_q*SLICE +: SLICE];

  // Explicit per-bit ripple chain for the active slice.
  always_comb begin
    chain     = '0;
    slice_sum = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < SLICE; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ chain[i];
      chain[i+1]   = (slice_a[i] & slice_b[i]) | (chain[i] & (slice_a[i] ^ slice_b[i]));
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q*SLICE +: SLICE] = slice_sum;
        carry_d = chain[SLICE];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          cout_d  = chain[SLICE];
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_carry_chain_seq_adder.sv
// Bench for carry_chain_seq_adder at WIDTH 16, 4 and 32: directed cases plus random
// traffic, checked each cycle against a cycle-count/arithmetic reference model.
module tb_carry_chain_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int W  = (g == 0) ? 16 : ((g == 1) ? 4 : 32);
    localparam int NS = W / 4;

    logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [W-1:0] a, b, sum;
    logic [W:0]   res_q[$];
    bit           done;
    int           m_acc;

    carry_chain_seq_adder #(.WIDTH(W), .SLICE(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
    );

    // Reference: an accepted op yields a+b+cin exactly NS clocks later and holds it
    // until taken; reset discards everything and zeroes the outputs.
    initial begin : model
      bit         known, pending, holding, cleared;
      int         left, cyc, last;
      logic [W:0] nxt, res;
      known = 0; pending = 0; holding = 0; cleared = 0;
      left = 0; cyc = 0; last = -1; nxt = '0; res = '0; m_acc = 0;
      forever begin
        @(negedge clk);
        if (known) begin
          check($sformatf("w%0d_in_ready", W), 64'(in_ready), 64'(!pending));
          check($sformatf("w%0d_busy", W), 64'(busy), 64'(pending));
          check($sformatf("w%0d_out_valid", W), 64'(out_valid), 64'(holding));
          if (holding) check($sformatf("w%0d_result", W), 64'({cout, sum}), 64'(res));
          if (cleared) check($sformatf("w%0d_reset_result", W), 64'({cout, sum}), 64'd0);
        end
        if (!rst_n) begin
          known = 1; pending = 0; holding = 0; cleared = 1; last = -1;
        end else if (known) begin
          if (holding) begin
            if (out_ready) begin
              holding = 0;
              pending = 0;
              res_q.push_back({cout, sum});
            end
          end else if (pending) begin
            left--;
            if (left == 0) begin
              holding = 1;
              res = nxt;
            end
          end else if (in_valid) begin
            if (last >= 0) check($sformatf("w%0d_interval", W), 64'(cyc - last >= NS + 2), 64'd1);
            pending = 1;
            cleared = 0;
            left    = NS;
            nxt     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            last    = cyc;
            m_acc++;
          end
        end
        cyc++;
      end
    end

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input int stall, input bit poke, input bit abort);
      int k;
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 100) begin @(posedge clk); #1; k++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (poke) begin
        a = ~ta; b = ~tb; cin = ~tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      if (abort) begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end else begin
        k = 0;
        while (!out_valid && k < 100) begin @(posedge clk); #1; k++; end
        check($sformatf("w%0d_result_timeout", W), 64'(out_valid), 64'd1);
        repeat (stall) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    endtask

    initial begin : drive
      int k, target;
      done = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      op(W'(16'hFFFF), W'(16'h0001), 1'b0, 0, 1'b0, 1'b0);
      op(W'(16'h1234), W'(16'h4321), 1'b1, 0, 1'b0, 1'b0);
      op(W'(16'h8000), W'(16'h8000), 1'b0, 0, 1'b0, 1'b0);
      op(W'(16'hABCD), W'(16'h1111), 1'b0, 5, 1'b0, 1'b0);
      op(W'(16'h0F0F), W'(16'h00F1), 1'b1, 0, 1'b1, 1'b0);
      op(W'(16'h7777), W'(16'h2222), 1'b0, 0, 1'b0, 1'b1);
      op(W'(16'h0001), W'(16'hFFFF), 1'b1, 0, 1'b0, 1'b0);
      target = m_acc + ((W == 16) ? 1000 : 300);
      k = 0;
      while (m_acc < target && k < 30000) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        k++;
      end
      check($sformatf("w%0d_random_progress", W), 64'(m_acc >= target), 64'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (NS + 4) @(posedge clk);
      #1 done = 1'b1;
    end
  end

  initial begin : finish_ctl
    int k;
    logic [16:0] pins[6];
    pins = '{17'h10000, 17'h05556, 17'h10000, 17'h0BCDE, 17'h01001, 17'h10001};
    k = 0;
    while (!(g_w[0].done && g_w[1].done && g_w[2].done) && k < 80000) begin
      @(posedge clk);
      k++;
    end
    check("all_done", 64'(g_w[0].done && g_w[1].done && g_w[2].done), 64'd1);
    check("w16_directed_count", 64'(g_w[0].res_q.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("w16_pin%0d", i), 64'(g_w[0].res_q[i]), 64'(pins[i]));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
